// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a Uart8 transmitter through a txStart/txBusy handshake.
// Bytes queue on wrEn and leave one frame at a time; a stuck UART raises timeoutErr.
module uart_tx_feeder #(
  parameter int DEPTH        = 16,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wrEn,
  input  logic [7:0]             wrData,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   timeoutErr,
  output logic                   txStart,
  output logic [7:0]             txIn,
  input  logic                   txBusy,
  input  logic                   txDone
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } stateT;

  stateT          state;
  stateT          stateNext;
  logic [7:0]     mem [DEPTH];
  logic [PW-1:0]  wrPtr;
  logic [PW-1:0]  rdPtr;
  logic [TW-1:0]  tmoCnt;
  logic           tmoHit;
  logic           pop;
  logic           push;
  logic           ovfSet;
  logic           tmoSet;
  logic           loadTx;
  logic           unusedTxDone;

  assign unusedTxDone = txDone;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) &&
                 (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign count = wrPtr - rdPtr;
  assign txStart = (state == START);

  assign tmoHit = (BUSY_TIMEOUT != 0) &&
                  (tmoCnt == TW'(BUSY_TIMEOUT - 1));

  always_comb begin
    stateNext = state;
    pop       = 1'b0;
    tmoSet    = 1'b0;
    loadTx    = 1'b0;
    unique case (state)
      IDLE: begin
        if (!flush && !empty) begin
          stateNext = START;
          loadTx    = 1'b1;
        end
      end
      START: begin
        if (flush) begin
          stateNext = IDLE;
        end else if (txBusy) begin
          pop       = 1'b1;
          stateNext = BUSY;
        end else if (tmoHit) begin
          pop       = 1'b1;
          tmoSet    = 1'b1;
          stateNext = IDLE;
        end
      end
      BUSY: begin
        if (!txBusy) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // A pop on the same edge frees the slot a full-FIFO write needs.
  assign push   = wrEn && !flush && (!full || pop);
  assign ovfSet = wrEn && !flush && full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr[AW-1:0]] <= wrData;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wrPtr      <= '0;
      rdPtr      <= '0;
      tmoCnt     <= '0;
      txIn       <= 8'h00;
      overflow   <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state <= stateNext;
      if (flush) begin
        wrPtr <= '0;
        rdPtr <= '0;
      end else begin
        if (push) wrPtr <= wrPtr + PW'(1);
        if (pop)  rdPtr <= rdPtr + PW'(1);
      end
      if (loadTx) txIn <= mem[rdPtr[AW-1:0]];
      if (state == START && stateNext == START)
        tmoCnt <= tmoCnt + TW'(1);
      else
        tmoCnt <= '0;
      if (flush)       overflow <= 1'b0;
      else if (ovfSet) overflow <= 1'b1;
      if (flush)       timeoutErr <= 1'b0;
      else if (tmoSet) timeoutErr <= 1'b1;
    end
  end

endmodule
